// File: rtl/vedic_mult_seq.sv
// Iterative Vedic multiplier: one H x H quadrant multiplier reused over four cycles, shifted partial products accumulated.
// Latency: out_valid rises 4 cycles after the accept edge; minimum initiation interval 6 cycles.
// Backpressure: in_ready is low in MUL/DONE; DONE holds product/out_valid until out_ready. VEDIC_SIGNED_EN selects two's-complement operands.

// Combinational N x N -> 2N Vedic multiplier, split recursively into quadrants down to 2x2 cells.
module vedic_quad #(
  parameter int N = 8
) (
  input  logic [N-1:0]   x_i,
  input  logic [N-1:0]   y_i,
  output logic [2*N-1:0] p_o
);
  if (N <= 2) begin : g_cell
    logic t1, t2, t3, c1;
    assign t1     = x_i[1] & y_i[0];
    assign t2     = x_i[0] & y_i[1];
    assign t3     = x_i[1] & y_i[1];
    assign c1     = t1 & t2;
    assign p_o[0] = x_i[0] & y_i[0];
    assign p_o[1] = t1 ^ t2;
    assign p_o[2] = t3 ^ c1;
    assign p_o[3] = t3 & c1;
  end else begin : g_split
    // Odd widths: the low half is zero-extended so all four sub-multipliers share width U.
    localparam int L  = N / 2;
    localparam int U  = N - L;
    localparam int PN = 2 * N;
    logic [U-1:0]   xl, xh, yl, yh;
    logic [2*U-1:0] ll, lh, hl, hh;
    assign xl = U'(x_i[L-1:0]);
    assign yl = U'(y_i[L-1:0]);
    assign xh = x_i[N-1:L];
    assign yh = y_i[N-1:L];
    vedic_quad #(.N(U)) u_ll (.x_i(xl), .y_i(yl), .p_o(ll));
    vedic_quad #(.N(U)) u_lh (.x_i(xl), .y_i(yh), .p_o(lh));
    vedic_quad #(.N(U)) u_hl (.x_i(xh), .y_i(yl), .p_o(hl));
    vedic_quad #(.N(U)) u_hh (.x_i(xh), .y_i(yh), .p_o(hh));
    // Vertical-and-crosswise combine; the true sum fits in 2N bits, so truncation is exact.
    assign p_o = PN'(ll) + ((PN'(lh) + PN'(hl)) << L) + (PN'(hh) << (2 * L));
  end
endmodule

module vedic_mult_seq #(
  parameter  int WIDTH = 16,
  localparam int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    product,
  output logic             busy
);
  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic             out_valid_q, busy_q, in_ready_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [H-1:0]     qx, qy;
  logic [WIDTH-1:0] pp;
  int               shamt;

`ifdef VEDIC_SIGNED_EN
  logic sign_q, sign_d;
  // Magnitudes stay WIDTH-bit unsigned so the most negative operand is representable.
  always_comb begin
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    sign_d = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Quadrant selection: cnt[1] picks the high half of a, cnt[0] the high half of b.
  assign qx = cnt_q[1] ? a_q[WIDTH-1:H] : a_q[H-1:0];
  assign qy = cnt_q[0] ? b_q[WIDTH-1:H] : b_q[H-1:0];

  vedic_quad #(.N(H)) u_quad (.x_i(qx), .y_i(qy), .p_o(pp));

  // Shift the current partial product into place and form the next accumulator and final product.
  always_comb begin
    shamt = 0;
    case (cnt_q)
      2'd0:    shamt = 0;
      2'd3:    shamt = 2 * H;
      default: shamt = H;
    endcase
    acc_d     = acc_q + (PW'(pp) << shamt);
    product_d = acc_d;
`ifdef VEDIC_SIGNED_EN
    if (sign_q) product_d = -acc_d;
`endif
  end

  // Control FSM with registered handshake outputs; reset wins over any same-edge handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef VEDIC_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a_mag;
            b_q        <= b_mag;
`ifdef VEDIC_SIGNED_EN
            sign_q     <= sign_d;
`endif
            acc_q      <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            product_q   <= product_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_vedic_mult_seq.sv
// Testbench for vedic_mult_seq (WIDTH=16): directed plan cases plus randomized operands against a plain-arithmetic model.
// Checks handshake timing (4-cycle latency, 6-cycle II), DONE hold under back-pressure, and mid-operation reset.
// Compile with +define+VEDIC_SIGNED_EN to exercise the two's-complement build.
module tb_vedic_mult_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;

  int          n_acc, n_out;
  int          acc_t [2];
  logic [31:0] got_p [2];
  logic        acc_now;

  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the mathematical product of the operands, reduced to 32 bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint p;
`ifdef VEDIC_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'({16'b0, x}) * longint'({16'b0, y});
`endif
    return p[31:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mult(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp, input int hold, input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk({tag, "/ready_timeout"}, in_ready, 1);
      return;
    end
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    for (int k = 1; k <= 4; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk({tag, "/out_valid_lat"}, out_valid, (k == 4));
      chk({tag, "/in_ready_busy"}, in_ready, 0);
      chk({tag, "/busy"}, busy, 1);
    end
    chk({tag, "/product"}, product, exp);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "/hold_valid"}, out_valid, 1);
      chk({tag, "/hold_product"}, product, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/handoff_valid"}, out_valid, 0);
    chk({tag, "/handoff_ready"}, in_ready, 1);
    chk({tag, "/handoff_busy"}, busy, 0);
    chk({tag, "/product_kept"}, product, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("rst/in_ready", in_ready, 0);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/busy", busy, 0);
    chk("rst/product", product, 0);
    rst = 1'b0;
    tick();
    chk("rst/in_ready_after", in_ready, 1);

    do_mult(16'h1234, 16'h5678, 32'h06260060, 0, "t1");
`ifdef VEDIC_SIGNED_EN
    do_mult(16'hFFFF, 16'hFFFF, 32'h00000001, 10, "t2");
`else
    do_mult(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10, "t2");
`endif

    // Back-to-back requests with in_valid held high and out_ready high.
    in_valid = 1'b1; a = 16'h0000; b = 16'hABCD; out_ready = 1'b1;
    n_acc = 0; n_out = 0;
    for (int t = 0; t < 30 && n_out < 2; t++) begin
      acc_now = in_ready & in_valid;
      tick();
      if (acc_now && n_acc < 2) begin
        acc_t[n_acc] = t;
        n_acc++;
        a = 16'h0100; b = 16'h0100;
        if (n_acc == 2) in_valid = 1'b0;
      end
      if (out_valid && n_out < 2) begin
        got_p[n_out] = product;
        n_out++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3/accepts", n_acc, 2);
    chk("t3/outputs", n_out, 2);
    chk("t3/ii", acc_t[1] - acc_t[0], 6);
    chk("t3/prod0", got_p[0], 32'h00000000);
    chk("t3/prod1", got_p[1], 32'h00010000);

    // Reset during MUL at cnt=2 discards the operation.
    tick();
    a = 16'h00FF; b = 16'h00FF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("t4/rst_in_ready", in_ready, 0);
    chk("t4/rst_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4/no_out_valid", out_valid, 0);
    end
    do_mult(16'h0003, 16'h0005, 32'h0000000F, 1, "t4b");

`ifdef VEDIC_SIGNED_EN
    do_mult(16'hFFFE, 16'h0003, 32'hFFFFFFFA, 2, "t5");
    do_mult(16'h8000, 16'h8000, 32'h40000000, 0, "t6a");
    do_mult(16'h8000, 16'h0001, 32'hFFFF8000, 0, "t6b");
    do_mult(16'h7FFF, 16'hFFFF, 32'hFFFF8001, 0, "t6c");
`else
    do_mult(16'hFFFE, 16'h0003, 32'h0002FFFA, 2, "t5");
`endif

    for (int i = 0; i < 150; i++) begin
      logic [15:0] x, y;
      x = pick();
      y = pick();
      do_mult(x, y, ref_mul(x, y), $urandom_range(0, 3), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vedic_mult_seq.md
Name: vedic_mult_seq

Overview:
- Parametrised, iterative Vedic (Urdhva-style quadrant) multiplier. Successor to the fixed-width combinational 16-bit multiplier.
- Reuses one half-width multiplier over four cycles: quadrant products aL*bL, aL*bH, aH*bL, aH*bH are accumulated with shifts.
- Uses valid/ready handshakes on input and output so it drops into the complex-multiplier datapath with back-pressure.
- Trades throughput for roughly one quarter of the combinational partial-product area.

Parameters:
- WIDTH, 16, operand width. Must be even and ≥ 4. H = WIDTH/2 is the quadrant width.
- PW, 2*WIDTH, product width. Derived; not to be overridden.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid, held until taken
- out_ready  input  1  downstream accepts product
- product  output  PW  a*b
- busy  output  1  high in MUL or DONE

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, cnt=0
  - operand registers and accumulator = 0
  - product=0, out_valid=0, busy=0
  - in_ready=0 while rst is high; it is 1 from the first edge after rst falls.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a and b into a_r and b_r, clear acc, set cnt=0, go to MUL.
  - MUL: in_ready=0. Each edge computes pp = x*y, where x and y are H-bit quadrant halves selected by cnt:
    - cnt 0: aL*bL, shift 0
    - cnt 1: aL*bH, shift H
    - cnt 2: aH*bL, shift H
    - cnt 3: aH*bH, shift 2H
  - MUL accumulate: acc <= acc + (pp << shift), truncated to PW bits. No overflow is possible because the final sum equals a*b < 2^PW. cnt increments; at cnt==3 load product <= final acc value, set out_valid=1, go to DONE.
  - DONE: product and out_valid held stable. On out_ready, out_valid <= 0 and go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency and throughput:
  - Accept edge N → out_valid visible after edge N+4, i.e. exactly 4 cycles.
  - Minimum initiation interval is 6 cycles (accept, 4×MUL, 1×DONE).
- Quadrant multiplier:
  - Purely combinational H×H → 2H.
  - Recursive Vedic decomposition down to 2×2 cells.
  - No registers inside it.
- Handshake rules:
  - a and b are sampled only on the accept edge; changes afterwards are ignored.
  - in_valid may drop without acceptance; no state change results.
  - out_ready low holds DONE indefinitely, with product unchanged.
  - out_ready high before out_valid has no effect.
- Reset mid-operation: the operation in flight is discarded, with no out_valid pulse, and the block returns to IDLE on that edge.
- rst has priority over all handshakes arriving on the same edge.
- product retains its last value after hand-off until the next completion overwrites it.

Optional Feature:
- Macro: VEDIC_SIGNED_EN
- Defined:
  - a and b are two's complement.
  - On accept, register the magnitudes |a| and |b| (WIDTH-bit unsigned, so -2^(WIDTH-1) is representable) and the sign bit s = a[MSB]^b[MSB].
  - When loading product at the end of MUL, output -acc if s=1. Latency is unchanged.
- Undefined: operands are unsigned, and no sign logic is synthesised.

Test Plan (WIDTH=16):
1. Reset release, then accept a=0x1234, b=0x5678 → out_valid exactly 4 cycles after accept; product=0x06260060; in_ready=0 during MUL and DONE.
2. a=0xFFFF, b=0xFFFF, out_ready held low 10 cycles → product=0xFFFE0001 stable and out_valid high throughout; on out_ready=1 → out_valid=0 and in_ready=1 the next cycle.
3. Two back-to-back requests with in_valid held high and out_ready=1 → second accept occurs 6 cycles after the first; products are 0x00000000 (0x0000*0xABCD) and 0x00010000 (0x0100*0x0100).
4. Assert rst for 1 cycle during MUL (cnt=2) after accepting 0x00FF*0x00FF → no out_valid; after reset, 0x0003*0x0005 → 0x0000000F.
5. a=0xFFFE, b=0x0003 → 0x0002FFFA without VEDIC_SIGNED_EN; 0xFFFFFFFA with it.
6. With VEDIC_SIGNED_EN: 0x8000*0x8000 → 0x40000000; 0x8000*0x0001 → 0xFFFF8000; 0x7FFF*0xFFFF → 0xFFFF8001.
